// File: rtl/axi_stream_arbiter_if.sv
// Bundle of the request-side and stream-side handshake signals of the
// axi_stream_arbiter.
//   req_request/req_valid/req_in_progress/req_last/req_data : from the submodules
//   req_ready                                               : to the submodules
//   M_AXIS_tdata/tvalid/tlast                               : stream toward downstream
//   M_AXIS_tready                                           : stream backpressure
// Modports:
//   master : the arbiter's view (drives the stream and the per-submodule ready)
//   slave  : the environment's view (submodules plus downstream sink)
interface axi_stream_arbiter_if #(
  parameter int NUM_REQ    = 5,
  parameter int DATA_WIDTH = 128
);
  logic [NUM_REQ-1:0]            req_request;
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_in_progress;
  logic [NUM_REQ-1:0]            req_last;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic [DATA_WIDTH-1:0]         M_AXIS_tdata;
  logic                          M_AXIS_tvalid;
  logic                          M_AXIS_tlast;
  logic                          M_AXIS_tready;

  modport master (
    input  req_request, req_valid, req_in_progress, req_last, req_data,
    output req_ready,
    output M_AXIS_tdata, M_AXIS_tvalid, M_AXIS_tlast,
    input  M_AXIS_tready
  );

  modport slave (
    output req_request, req_valid, req_in_progress, req_last, req_data,
    input  req_ready,
    input  M_AXIS_tdata, M_AXIS_tvalid, M_AXIS_tlast,
    output M_AXIS_tready
  );
endinterface

// File: rtl/axi_stream_arbiter.sv
// Round-robin arbiter sharing one AXI-Stream master among NUM_REQ snoop
// submodules. A grant is held until the granted submodule's last beat (or
// until it abandons), then the pointer rotates past it.
// Ports:
//   clk        : single clock, rising edge
//   reset      : synchronous, active-high
//   bus        : axi_stream_arbiter_if.master (request side + stream side)
//   grant_id   : index of the current / most recently granted requester
//   busy       : high while a grant is held
//   pkt_count  : completed packets (tlast handshakes), wraps silently
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | no grant; pick next requester after rr_ptr if any is pending
// GRANT | stream muxed from grant_oh; wait for tlast handshake/abandon
module axi_stream_arbiter #(
  parameter int NUM_REQ    = 5,
  parameter int DATA_WIDTH = 128,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  axi_stream_arbiter_if.master       bus,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy,
  output logic [CNT_WIDTH-1:0]       pkt_count
);

  localparam int ID_W = $clog2(NUM_REQ);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t               state_q, state_d;
  logic [NUM_REQ-1:0]   grant_oh_q, grant_oh_d;
  logic [ID_W-1:0]      grant_id_q, grant_id_d;
  logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [CNT_WIDTH-1:0] pkt_count_q, pkt_count_d;

  logic                  sel_valid;
  logic                  sel_last;
  logic                  sel_request;
  logic                  sel_in_progress;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [ID_W:0]         pick;

  // First requester after ptr in circular order. Scanning from the far end
  // lets the nearest hit overwrite the others. MSB flags a hit.
  function automatic logic [ID_W:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                            input logic [ID_W-1:0]    ptr);
    logic [ID_W:0] res;
    int            idx;
    res = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (req[idx]) res = {1'b1, ID_W'(idx)};
    end
    return res;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      grant_oh_q  <= '0;
      grant_id_q  <= '0;
      rr_ptr_q    <= ID_W'(NUM_REQ - 1);
      pkt_count_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_oh_q  <= grant_oh_d;
      grant_id_q  <= grant_id_d;
      rr_ptr_q    <= rr_ptr_d;
      pkt_count_q <= pkt_count_d;
    end
  end

  // Selection uses only the registered one-hot, so req_ready never depends
  // combinationally on req_valid.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_oh_q[i]) sel_data = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
    sel_valid       = |(bus.req_valid & grant_oh_q);
    sel_last        = |(bus.req_last & grant_oh_q);
    sel_request     = |(bus.req_request & grant_oh_q);
    sel_in_progress = |(bus.req_in_progress & grant_oh_q);
    pick            = rr_pick(bus.req_request, rr_ptr_q);
  end

  always_comb begin
    state_d           = state_q;
    grant_oh_d        = grant_oh_q;
    grant_id_d        = grant_id_q;
    rr_ptr_d          = rr_ptr_q;
    pkt_count_d       = pkt_count_q;
    bus.req_ready     = '0;
    bus.M_AXIS_tvalid = 1'b0;
    bus.M_AXIS_tlast  = 1'b0;
    bus.M_AXIS_tdata  = '0;

    case (state_q)
      IDLE: begin
        if (pick[ID_W]) begin
          grant_id_d = pick[ID_W-1:0];
          grant_oh_d = NUM_REQ'(1) << pick[ID_W-1:0];
          state_d    = GRANT;
        end
      end
      GRANT: begin
        bus.req_ready     = grant_oh_q & {NUM_REQ{bus.M_AXIS_tready}};
        bus.M_AXIS_tvalid = sel_valid;
        bus.M_AXIS_tlast  = sel_valid & sel_last;
        bus.M_AXIS_tdata  = sel_valid ? sel_data : '0;
        if (sel_valid && bus.M_AXIS_tready && sel_last) begin
          pkt_count_d = pkt_count_q + CNT_WIDTH'(1);
          rr_ptr_d    = grant_id_q;
          grant_oh_d  = '0;
          state_d     = IDLE;
        end else if (!sel_request && !sel_in_progress && !sel_valid) begin
          // Submodule withdrew before sending anything: release uncounted.
          rr_ptr_d    = grant_id_q;
          grant_oh_d  = '0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign grant_id  = grant_id_q;
  assign busy      = (state_q == GRANT);
  assign pkt_count = pkt_count_q;

endmodule

// File: tb/tb_axi_stream_arbiter.sv
// Directed bench for axi_stream_arbiter. Inputs change on the falling edge,
// outputs are sampled 1 time unit later, well away from the rising edge.
// pkt_count is built 4 bits wide so the wrap can be reached quickly.
module tb_axi_stream_arbiter;
  localparam int NR = 5;
  localparam int DW = 128;
  localparam int CW = 4;

  logic          clk;
  logic          reset;
  logic [2:0]    grant_id;
  logic          busy;
  logic [CW-1:0] pkt_count;

  int n_checks;
  int n_errors;
  int hs;
  int beats;
  int pat [6] = '{1, 0, 1, 1, 0, 1};

  axi_stream_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) ifc ();

  axi_stream_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (ifc),
    .grant_id  (grant_id),
    .busy      (busy),
    .pkt_count (pkt_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] dval(input int i, input int beat);
    return {96'hCAFE, 16'(i), 16'(beat)};
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_all_data();
    for (int i = 0; i < NR; i++) ifc.req_data[i*DW +: DW] = dval(i, 0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset = 1'b1;
    ifc.req_request     = '0;
    ifc.req_valid       = '0;
    ifc.req_in_progress = '0;
    ifc.req_last        = '0;
    ifc.req_data        = '0;
    ifc.M_AXIS_tready   = 1'b0;
    set_all_data();
    repeat (2) tick();
    #1;
    check_val("rst_busy", 128'(busy), 128'(0));
    check_val("rst_tvalid", 128'(ifc.M_AXIS_tvalid), 128'(0));
    check_val("rst_ready", 128'(ifc.req_ready), 128'(0));
    check_val("rst_gid", 128'(grant_id), 128'(0));
    check_val("rst_pkt", 128'(pkt_count), 128'(0));

    // 1: requesters 0 and 2, one-beat packets, one IDLE cycle between
    reset = 1'b0;
    ifc.req_request   = 5'b00101;
    ifc.M_AXIS_tready = 1'b1;
    tick();
    ifc.req_valid = 5'b00001;
    ifc.req_last  = 5'b00001;
    #1;
    check_val("t1_busy0", 128'(busy), 128'(1));
    check_val("t1_gid0", 128'(grant_id), 128'(0));
    check_val("t1_ready0", 128'(ifc.req_ready), 128'(5'b00001));
    check_val("t1_data0", ifc.M_AXIS_tdata, dval(0, 0));
    check_val("t1_tlast0", 128'(ifc.M_AXIS_tlast), 128'(1));
    tick();
    ifc.req_valid = '0;
    #1;
    check_val("t1_idle", 128'(busy), 128'(0));
    check_val("t1_pkt1", 128'(pkt_count), 128'(1));
    check_val("t1_ready_idle", 128'(ifc.req_ready), 128'(0));
    tick();
    ifc.req_valid = 5'b00100;
    ifc.req_last  = 5'b00100;
    #1;
    check_val("t1_gid2", 128'(grant_id), 128'(2));
    check_val("t1_ready2", 128'(ifc.req_ready), 128'(5'b00100));
    check_val("t1_data2", ifc.M_AXIS_tdata, dval(2, 0));
    tick();
    ifc.req_request = '0;
    ifc.req_valid   = '0;
    ifc.req_last    = '0;
    #1;
    check_val("t1_pkt2", 128'(pkt_count), 128'(2));

    // 2: 4-beat burst from requester 1 under tready pattern 1,0,1,1,0,1
    ifc.req_request     = 5'b00010;
    ifc.req_in_progress = 5'b00010;
    tick();
    #1;
    check_val("t2_gid", 128'(grant_id), 128'(1));
    hs = 0;
    beats = 0;
    for (int c = 0; c < 6; c++) begin
      ifc.M_AXIS_tready = pat[c][0];
      ifc.req_valid     = 5'b00010;
      ifc.req_last      = (beats == 3) ? 5'b00010 : 5'b00000;
      ifc.req_data[1*DW +: DW] = dval(1, beats);
      if (beats == 3) ifc.req_request = '0;
      #1;
      check_val($sformatf("t2_busy_c%0d", c), 128'(busy), 128'(1));
      check_val($sformatf("t2_ready_c%0d", c), 128'(ifc.req_ready), 128'(pat[c] << 1));
      check_val($sformatf("t2_data_c%0d", c), ifc.M_AXIS_tdata, dval(1, beats));
      if (ifc.M_AXIS_tvalid && ifc.M_AXIS_tready) hs++;
      if (pat[c] != 0) beats++;
      tick();
    end
    ifc.req_valid       = '0;
    ifc.req_last        = '0;
    ifc.req_in_progress = '0;
    ifc.M_AXIS_tready   = 1'b1;
    #1;
    check_val("t2_beats", 128'(hs), 128'(4));
    check_val("t2_busy_end", 128'(busy), 128'(0));
    check_val("t2_pkt", 128'(pkt_count), 128'(3));
    tick();
    #1;
    check_val("t2_no_regrant", 128'(busy), 128'(0));

    // 3: all five requesting, one-beat packets, round-robin from 0
    reset = 1'b1;
    tick();
    reset = 1'b0;
    set_all_data();
    ifc.req_request = 5'b11111;
    ifc.req_valid   = 5'b11111;
    ifc.req_last    = 5'b11111;
    for (int p = 0; p < 10; p++) begin
      tick();
      #1;
      check_val($sformatf("t3_gid_p%0d", p), 128'(grant_id), 128'(p % 5));
      check_val($sformatf("t3_data_p%0d", p), ifc.M_AXIS_tdata, dval(p % 5, 0));
      tick();
    end
    #1;
    check_val("t3_pkt", 128'(pkt_count), 128'(10));

    // 4: reset during beat 2 of a 3-beat burst from requester 3
    ifc.req_request     = 5'b01000;
    ifc.req_valid       = '0;
    ifc.req_last        = '0;
    ifc.req_in_progress = 5'b01000;
    tick();
    ifc.req_valid = 5'b01000;
    #1;
    check_val("t4_gid3", 128'(grant_id), 128'(3));
    tick();
    ifc.req_data[3*DW +: DW] = dval(3, 1);
    reset = 1'b1;
    tick();
    #1;
    check_val("t4_tvalid", 128'(ifc.M_AXIS_tvalid), 128'(0));
    check_val("t4_ready", 128'(ifc.req_ready), 128'(0));
    check_val("t4_busy", 128'(busy), 128'(0));
    check_val("t4_pkt", 128'(pkt_count), 128'(0));
    check_val("t4_gid", 128'(grant_id), 128'(0));
    reset = 1'b0;
    ifc.req_request     = 5'b01001;
    ifc.req_valid       = '0;
    ifc.req_in_progress = '0;
    tick();
    #1;
    check_val("t4_next_gid", 128'(grant_id), 128'(0));
    ifc.req_request = '0;
    ifc.req_valid   = 5'b00001;
    ifc.req_last    = 5'b00001;
    tick();
    ifc.req_valid = '0;
    ifc.req_last  = '0;
    #1;
    check_val("t4_pkt1", 128'(pkt_count), 128'(1));

    // 5: requester 1 granted, then withdraws before any beat
    ifc.req_request = 5'b00110;
    tick();
    #1;
    check_val("t5_gid1", 128'(grant_id), 128'(1));
    ifc.req_request = 5'b00100;
    #1;
    check_val("t5_tvalid", 128'(ifc.M_AXIS_tvalid), 128'(0));
    tick();
    #1;
    check_val("t5_abandon", 128'(busy), 128'(0));
    check_val("t5_pkt", 128'(pkt_count), 128'(1));
    tick();
    ifc.req_valid = 5'b00100;
    ifc.req_last  = 5'b00100;
    #1;
    check_val("t5_gid2", 128'(grant_id), 128'(2));
    tick();
    #1;
    check_val("t5_pkt2", 128'(pkt_count), 128'(2));

    // 6: sole requester re-granted after each IDLE cycle; counter wraps
    ifc.req_request = 5'b00001;
    ifc.req_valid   = 5'b00001;
    ifc.req_last    = 5'b00001;
    for (int p = 0; p < 13; p++) begin
      tick();
      #1;
      if (p == 0) check_val("t6_regrant", 128'(busy), 128'(1));
      tick();
      #1;
      if (p == 0) check_val("t6_idle_gap", 128'(busy), 128'(0));
    end
    check_val("t6_pkt_max", 128'(pkt_count), 128'(15));
    tick();
    tick();
    #1;
    check_val("t6_pkt_wrap", 128'(pkt_count), 128'(0));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
